write_back_unit: RTL and testbench

- Final pipeline stage. It accepts completed results from the execute/memory stage through a valid/ready handshake and buffers them in a 2-entry queue.
- It drives the single register-file write port (write address, write data, write enable), which is the port operand fetch leaves idle.
- It keeps a per-register pending-write scoreboard. Operand fetch uses the scoreboard to stall on RAW hazards.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/write_back_unit_if.sv | 51 +++++
 rtl/wb_result_queue.sv | 62 ++++++
 rtl/write_back_unit.sv | 135 +++++++++++++
 tb/tb_write_back_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the result-queue entry type for the write-back stage.
// The WB_* values are the default build; the top re-exports them as parameters.
package wb_pkg;

    localparam int WB_DATA_W     = 64;
    localparam int WB_REG_ADDR_W = 4;
    localparam int WB_NUM_REGS   = 2 ** WB_REG_ADDR_W;
    localparam int WB_Q_DEPTH    = 2;
    localparam int WB_PEND_W     = 2;

    // A pending counter at this value blocks further issues to its register.
    localparam logic [WB_PEND_W-1:0] PEND_MAX = '1;

    typedef struct packed {
        logic [WB_REG_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0]     data;
    } wb_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/write_back_unit_if.sv
// Issue, result and register-file/bypass signals of the write-back stage.
// slave = the write-back unit, master = its neighbours (fetch, execute, RF).
interface write_back_unit_if
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int NUM_REGS   = WB_NUM_REGS
) ();

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_ready;

    logic                  res_valid;
    logic                  res_ready;
    logic                  res_reg_write;
    logic                  res_mem_to_reg;
    logic [REG_ADDR_W-1:0] res_rd;
    logic [DATA_W-1:0]     res_alu_data;
    logic [DATA_W-1:0]     res_mem_data;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [NUM_REGS-1:0]   busy_mask;

    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]     fwd_data;
    logic                  err_sticky;

    modport slave (
        input  issue_valid, issue_rd,
        output issue_ready,
        input  res_valid, res_reg_write, res_mem_to_reg, res_rd, res_alu_data, res_mem_data,
        output res_ready,
        output rf_we, rf_waddr, rf_wdata, busy_mask,
        output fwd_valid, fwd_addr, fwd_data, err_sticky
    );

    modport master (
        output issue_valid, issue_rd,
        input  issue_ready,
        output res_valid, res_reg_write, res_mem_to_reg, res_rd, res_alu_data, res_mem_data,
        input  res_ready,
        input  rf_we, rf_waddr, rf_wdata, busy_mask,
        input  fwd_valid, fwd_addr, fwd_data, err_sticky
    );

endinterface

// File: rtl/wb_result_queue.sv
// Small synchronous FIFO with wrap-around pointers; head is visible combinationally.
// Push is ignored when full; pop is ignored when empty; push+pop together is allowed when not full.
module wb_result_queue
    import wb_pkg::*;
#(
    parameter type T       = wb_entry_t,
    parameter int  Q_DEPTH = WB_Q_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_push_dat,
    input  logic i_pop,
    output T     o_head_dat,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam int CW = cnt_w(Q_DEPTH);

    T                r_mem [Q_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full     = (r_count == CW'(Q_DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rptr];

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: queues results, drives the RF write port, tracks pending writes. Optional bypass: WB_FORWARD_EN.
// Latency: accept at edge N -> rf_we during cycle N+1. res_ready = queue not full; issue_ready = counter not saturated.
module write_back_unit
    import wb_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int NUM_REGS   = WB_NUM_REGS,
    parameter int Q_DEPTH    = WB_Q_DEPTH,
    parameter int PEND_W     = WB_PEND_W
) (
    input  logic                clk,
    input  logic                rst_n,
    write_back_unit_if.slave    wb
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } entry_t;

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    entry_t                w_entry;
    entry_t                w_head;
    logic                  w_q_full;
    logic                  w_q_empty;
    logic                  w_push;
    logic                  w_issue_fire;

    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic                  r_err;

    logic [PEND_W-1:0]     r_pend     [NUM_REGS];
    logic [PEND_W-1:0]     w_pend_nxt [NUM_REGS];
    logic [NUM_REGS-1:0]   w_inc_vec;
    logic [NUM_REGS-1:0]   w_dec_vec;
    logic                  w_underflow;
    logic [NUM_REGS-1:0]   w_busy;

    // Results that do not write a register are consumed here and never queued.
    assign wb.res_ready = !w_q_full;
    assign w_push       = wb.res_valid && !w_q_full && wb.res_reg_write;
    assign w_entry      = '{rd:   wb.res_rd,
                            data: wb.res_mem_to_reg ? wb.res_mem_data : wb.res_alu_data};

    wb_result_queue #(
        .T       (entry_t),
        .Q_DEPTH (Q_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat (w_entry),
        .i_pop      (!w_q_empty),
        .o_head_dat (w_head),
        .o_full     (w_q_full),
        .o_empty    (w_q_empty)
    );

    assign wb.issue_ready = (r_pend[wb.issue_rd] != CNT_MAX);
    assign w_issue_fire   = wb.issue_valid && wb.issue_ready;

    always_comb begin
        w_inc_vec = '0;
        w_dec_vec = '0;
        if (w_issue_fire) begin
            w_inc_vec[wb.issue_rd] = 1'b1;
        end
        if (r_rf_we) begin
            w_dec_vec[r_rf_waddr] = 1'b1;
        end
    end

    // Same-edge issue and commit to one register cancel; a lone commit at zero is an underflow.
    always_comb begin
        w_underflow = 1'b0;
        w_busy      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pend_nxt[i] = r_pend[i];
            w_busy[i]     = (r_pend[i] != '0);
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
                w_pend_nxt[i] = r_pend[i] + 1'b1;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                if (r_pend[i] == '0) begin
                    w_underflow = 1'b1;
                end else begin
                    w_pend_nxt[i] = r_pend[i] - 1'b1;
                end
            end
        end
    end

    assign wb.busy_mask = w_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            r_rf_we <= !w_q_empty;
            if (!w_q_empty) begin
                r_rf_waddr <= w_head.rd;
                r_rf_wdata <= w_head.data;
            end
            r_err <= r_err | w_underflow;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
        end
    end

    assign wb.rf_we      = r_rf_we;
    assign wb.rf_waddr   = r_rf_waddr;
    assign wb.rf_wdata   = r_rf_wdata;
    assign wb.err_sticky = r_err;

`ifdef WB_FORWARD_EN
    assign wb.fwd_valid = r_rf_we;
    assign wb.fwd_addr  = r_rf_waddr;
    assign wb.fwd_data  = r_rf_wdata;
`else
    assign wb.fwd_valid = 1'b0;
    assign wb.fwd_addr  = '0;
    assign wb.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Bench for write_back_unit: directed scenarios plus a randomized run against a queue/counter reference model.
module tb_write_back_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    write_back_unit_if bus ();

    write_back_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [63:0] data;
    } ent_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic v, input logic [3:0] rd, input logic [63:0] d,
                             input logic m2r, input logic wr);
        bus.res_valid      = v;
        bus.res_rd         = rd;
        bus.res_reg_write  = wr;
        bus.res_mem_to_reg = m2r;
        bus.res_alu_data   = m2r ? {$urandom, $urandom} : d;
        bus.res_mem_data   = m2r ? d : {$urandom, $urandom};
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0h exp=0", bus.rf_we); end
        total++; if (bus.busy_mask !== 16'h0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", bus.busy_mask); end
        total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0h exp=1", bus.issue_ready); end
        total++; if (bus.res_ready !== 1'b1) begin bad++; $display("FAIL reset_res_ready got=%0h exp=1", bus.res_ready); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err got=%0h exp=0", bus.err_sticky); end
        total++; if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL reset_fwd_valid got=%0h exp=0", bus.fwd_valid); end
    endtask

    task automatic test_single_write();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd3;
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.busy_mask[3] !== 1'b1) begin bad++; $display("FAIL single_busy_after_issue got=%0h exp=1", bus.busy_mask[3]); end
        drive_res(1'b1, 4'd3, 64'h1234, 1'b0, 1'b1);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL single_we_early got=%0h exp=0", bus.rf_we); end
        tick();
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0h exp=1", bus.rf_we); end
        total++; if (bus.rf_waddr !== 4'd3) begin bad++; $display("FAIL single_waddr got=%0h exp=3", bus.rf_waddr); end
        total++; if (bus.rf_wdata !== 64'h1234) begin bad++; $display("FAIL single_wdata got=%0h exp=1234", bus.rf_wdata); end
        total++; if (bus.busy_mask[3] !== 1'b1) begin bad++; $display("FAIL single_busy_during_write got=%0h exp=1", bus.busy_mask[3]); end
`ifdef WB_FORWARD_EN
        total++; if (bus.fwd_valid !== 1'b1 || bus.fwd_data !== 64'h1234) begin bad++; $display("FAIL single_fwd got=%0h/%0h exp=1/1234", bus.fwd_valid, bus.fwd_data); end
`endif
        tick();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL single_we_once got=%0h exp=0", bus.rf_we); end
        total++; if (bus.busy_mask[3] !== 1'b0) begin bad++; $display("FAIL single_busy_cleared got=%0h exp=0", bus.busy_mask[3]); end
        // A non-writing result must be dropped.
        drive_res(1'b1, 4'd4, 64'hdead, 1'b0, 1'b0);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        tick();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL drop_no_write got=%0h exp=0", bus.rf_we); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d [3];
        for (int i = 0; i < 3; i++) begin
            d[i] = {$urandom, $urandom};
            bus.issue_valid = 1'b1;
            bus.issue_rd    = 4'(i + 1);
            tick();
        end
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive_res(1'b1, 4'(i + 1), d[i], 1'(i == 1), 1'b1);
            else       drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
            total++; if (bus.res_ready !== 1'b1) begin bad++; $display("FAIL b2b_res_ready[%0d] got=%0h exp=1", i, bus.res_ready); end
            tick();
            if (i > 0) begin
                total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'(i) || bus.rf_wdata !== d[i-1]) begin
                    bad++; $display("FAIL b2b_write[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i, d[i-1]);
                end
            end
        end
        tick();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0h exp=0", bus.rf_we); end
        total++; if (bus.busy_mask[3:1] !== 3'b000) begin bad++; $display("FAIL b2b_busy got=%0h exp=0", bus.busy_mask[3:1]); end
    endtask

    task automatic test_saturate();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd5;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL sat_ready[%0d] got=%0h exp=1", i, bus.issue_ready); end
            tick();
        end
        total++; if (bus.issue_ready !== 1'b0) begin bad++; $display("FAIL sat_stall got=%0h exp=0", bus.issue_ready); end
        tick();
        total++; if (bus.issue_ready !== 1'b0 || bus.busy_mask[5] !== 1'b1) begin bad++; $display("FAIL sat_hold got=%0h/%0h exp=0/1", bus.issue_ready, bus.busy_mask[5]); end
        bus.issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_res(1'b1, 4'd5, {$urandom, $urandom}, 1'b0, 1'b1);
            tick();
        end
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        total++; if (bus.issue_ready !== 1'b1) begin bad++; $display("FAIL sat_release got=%0h exp=1", bus.issue_ready); end
        tick();
        tick();
        total++; if (bus.busy_mask[5] !== 1'b0) begin bad++; $display("FAIL sat_busy_clear got=%0h exp=0", bus.busy_mask[5]); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL sat_err got=%0h exp=0", bus.err_sticky); end
    endtask

    task automatic test_same_edge();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 4'd7;
        tick();
        bus.issue_valid = 1'b0;
        drive_res(1'b1, 4'd7, 64'h77, 1'b0, 1'b1);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        tick();
        total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd7) begin bad++; $display("FAIL same_commit got=%0h/%0h exp=1/7", bus.rf_we, bus.rf_waddr); end
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        total++; if (bus.busy_mask[7] !== 1'b1) begin bad++; $display("FAIL same_busy got=%0h exp=1", bus.busy_mask[7]); end
        drive_res(1'b1, 4'd7, 64'h78, 1'b0, 1'b1);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        tick();
        tick();
        total++; if (bus.busy_mask[7] !== 1'b0) begin bad++; $display("FAIL same_busy_clear got=%0h exp=0", bus.busy_mask[7]); end
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL same_err got=%0h exp=0", bus.err_sticky); end
    endtask

    task automatic test_underflow();
        drive_res(1'b1, 4'd9, 64'h99, 1'b1, 1'b1);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        tick();
        total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd9 || bus.rf_wdata !== 64'h99) begin bad++; $display("FAIL uf_write got=%0h/%0h/%0h exp=1/9/99", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
`ifdef WB_FORWARD_EN
        total++; if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 4'd9) begin bad++; $display("FAIL uf_fwd got=%0h/%0h exp=1/9", bus.fwd_valid, bus.fwd_addr); end
`else
        total++; if (bus.fwd_valid !== 1'b0 || bus.fwd_addr !== 4'd0) begin bad++; $display("FAIL uf_fwd_tied got=%0h/%0h exp=0/0", bus.fwd_valid, bus.fwd_addr); end
`endif
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL uf_err_early got=%0h exp=0", bus.err_sticky); end
        tick();
        total++; if (bus.err_sticky !== 1'b1 || bus.busy_mask[9] !== 1'b0) begin bad++; $display("FAIL uf_err got=%0h/%0h exp=1/0", bus.err_sticky, bus.busy_mask[9]); end
        repeat (3) tick();
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%0h exp=1", bus.err_sticky); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL uf_reset_clear got=%0h exp=0", bus.err_sticky); end
    endtask

    task automatic test_reset_mid_op();
        drive_res(1'b1, 4'd2, 64'h22, 1'b0, 1'b1);
        tick();
        drive_res(1'b0, 4'd0, 64'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL midrst_no_write got=%0h exp=0", bus.rf_we); end
        tick();
        total++; if (bus.rf_we !== 1'b0 || bus.err_sticky !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0h/%0h exp=0/0", bus.rf_we, bus.err_sticky); end
    endtask

    task automatic test_random();
        ent_t        mq[$];
        ent_t        nxt;
        logic [3:0]  outst[$];
        int          mpend [16];
        logic        mo_we, merr, nxt_we, fire, acc, inc, dec;
        logic [3:0]  mo_addr, ird, rrd;
        logic [63:0] mo_data, alu, mem;
        logic        iv, rv, wr, m2r;
        logic [15:0] mbusy;

        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        foreach (mpend[r]) mpend[r] = 0;
        mo_we = 1'b0; mo_addr = '0; mo_data = '0; merr = 1'b0;
        nxt = '{rd: 4'd0, data: 64'd0};

        for (int cyc = 0; cyc < 800; cyc++) begin
            iv  = ($urandom_range(0, 2) == 0);
            ird = 4'($urandom_range(0, 7));
            rv  = $urandom_range(0, 1) == 1;
            wr  = ($urandom_range(0, 9) != 0);
            m2r = $urandom_range(0, 1) == 1;
            alu = {$urandom, $urandom};
            mem = {$urandom, $urandom};
            if (wr && outst.size() > 0 && $urandom_range(0, 9) != 0) rrd = outst[0];
            else rrd = 4'($urandom_range(0, 15));
            bus.issue_valid    = iv;
            bus.issue_rd       = ird;
            bus.res_valid      = rv;
            bus.res_reg_write  = wr;
            bus.res_mem_to_reg = m2r;
            bus.res_rd         = rrd;
            bus.res_alu_data   = alu;
            bus.res_mem_data   = mem;
            #1;

            for (int r = 0; r < 16; r++) mbusy[r] = (mpend[r] != 0);
            total++; if (bus.rf_we !== mo_we) begin bad++; $display("FAIL rnd_we[%0d] got=%0h exp=%0h", cyc, bus.rf_we, mo_we); end
            if (mo_we) begin
                total++; if (bus.rf_waddr !== mo_addr || bus.rf_wdata !== mo_data) begin
                    bad++; $display("FAIL rnd_wr[%0d] got=%0h/%0h exp=%0h/%0h", cyc, bus.rf_waddr, bus.rf_wdata, mo_addr, mo_data);
                end
            end
            total++; if (bus.busy_mask !== mbusy) begin bad++; $display("FAIL rnd_busy[%0d] got=%0h exp=%0h", cyc, bus.busy_mask, mbusy); end
            total++; if (bus.issue_ready !== (mpend[ird] != 3)) begin bad++; $display("FAIL rnd_issue_ready[%0d] got=%0h exp=%0h", cyc, bus.issue_ready, mpend[ird] != 3); end
            total++; if (bus.res_ready !== (mq.size() < 2)) begin bad++; $display("FAIL rnd_res_ready[%0d] got=%0h exp=%0h", cyc, bus.res_ready, mq.size() < 2); end
            total++; if (bus.err_sticky !== merr) begin bad++; $display("FAIL rnd_err[%0d] got=%0h exp=%0h", cyc, bus.err_sticky, merr); end
`ifdef WB_FORWARD_EN
            total++; if (bus.fwd_valid !== mo_we) begin bad++; $display("FAIL rnd_fwd[%0d] got=%0h exp=%0h", cyc, bus.fwd_valid, mo_we); end
`else
            total++; if (bus.fwd_valid !== 1'b0) begin bad++; $display("FAIL rnd_fwd_tied[%0d] got=%0h exp=0", cyc, bus.fwd_valid); end
`endif

            fire = iv && (mpend[ird] != 3);
            acc  = rv && (mq.size() < 2);
            if (fire) outst.push_back(ird);
            if (acc && wr && outst.size() > 0 && outst[0] == rrd) void'(outst.pop_front());
            nxt_we = (mq.size() > 0);
            if (nxt_we) nxt = mq.pop_front();
            if (acc && wr) mq.push_back('{rd: rrd, data: m2r ? mem : alu});
            for (int r = 0; r < 16; r++) begin
                inc = fire && (ird == 4'(r));
                dec = mo_we && (mo_addr == 4'(r));
                if (inc && !dec) mpend[r]++;
                else if (dec && !inc) begin
                    if (mpend[r] == 0) merr = 1'b1;
                    else mpend[r]--;
                end
            end
            mo_we = nxt_we;
            if (nxt_we) begin
                mo_addr = nxt.rd;
                mo_data = nxt.data;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_saturate();
        test_same_edge();
        test_underflow();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
